// File: rtl/ofdm_tx_frame_sched.sv
// Frame scheduler between a symbol source and the OFDM TX chain.
// Runs FRM_NUM frames of FRM_LEN symbols with GAP idle cycles between.
//
// Ports:
//   CLK_I, RST_I          clock, synchronous active-high reset
//   START_I, ABORT_I      run control (abort wins outside IDLE)
//   FRM_LEN_I, FRM_NUM_I,
//   GAP_I                 run configuration, latched on start
//   DAT_I, WE_I, STB_I,
//   CYC_I, ACK_O          source side bus
//   DAT_O, WE_O, STB_O,
//   CYC_O, ACK_I          TX chain input bus
//   TX_CYC_I              TX chain output activity, used to detect drain
//   BUSY_O, FRM_CNT_O,
//   DONE_O                run status
module ofdm_tx_frame_sched #(
    parameter int LEN_W = 12,
    parameter int NUM_W = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             START_I,
    input  logic             ABORT_I,
    input  logic [LEN_W-1:0] FRM_LEN_I,
    input  logic [NUM_W-1:0] FRM_NUM_I,
    input  logic [LEN_W-1:0] GAP_I,
    input  logic [1:0]       DAT_I,
    input  logic             WE_I,
    input  logic             STB_I,
    input  logic             CYC_I,
    output logic             ACK_O,
    output logic [1:0]       DAT_O,
    output logic             WE_O,
    output logic             STB_O,
    output logic             CYC_O,
    input  logic             ACK_I,
    input  logic             TX_CYC_I,
    output logic             BUSY_O,
    output logic [NUM_W-1:0] FRM_CNT_O,
    output logic             DONE_O
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [NUM_W-1:0]   num_q;
    logic [LEN_W-1:0]   gap_q;
    logic [LEN_W-1:0]   sym_cnt;
    logic [LEN_W-1:0]   gap_cnt;
    logic [NUM_W-1:0]   frm_cnt;
    logic               seen;
    logic               busy_q;
    logic               done_q;

    logic               in_xfer;
    logic               src_ok;
    logic               xfer;
    logic               last_sym;
    logic [NUM_W-1:0]   frm_nxt;

    // Bus pass-through is combinational so a transfer costs no latency.
    assign in_xfer  = (state == XFER);
    assign src_ok   = STB_I & WE_I & CYC_I;
    assign CYC_O    = in_xfer;
    assign STB_O    = in_xfer & src_ok;
    assign WE_O     = in_xfer & src_ok;
    assign DAT_O    = in_xfer ? DAT_I : 2'b00;
    assign ACK_O    = ACK_I & STB_O;
    assign xfer     = STB_O & ACK_I;
    assign last_sym = (sym_cnt == len_q - LEN_W'(1));
    assign frm_nxt  = frm_cnt + NUM_W'(1);

    assign BUSY_O    = busy_q;
    assign FRM_CNT_O = frm_cnt;
    assign DONE_O    = done_q;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= IDLE;
            len_q   <= '0;
            num_q   <= '0;
            gap_q   <= '0;
            sym_cnt <= '0;
            gap_cnt <= '0;
            frm_cnt <= '0;
            seen    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && ABORT_I) begin
                // Abort keeps the frame count of the partial run.
                state  <= IDLE;
                seen   <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (START_I) begin
                            len_q   <= FRM_LEN_I;
                            num_q   <= FRM_NUM_I;
                            gap_q   <= GAP_I;
                            sym_cnt <= '0;
                            frm_cnt <= '0;
                            seen    <= 1'b0;
                            // An empty run completes without leaving IDLE.
                            if (FRM_LEN_I == '0 || FRM_NUM_I == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state  <= XFER;
                                busy_q <= 1'b1;
                            end
                        end
                    end
                    XFER: begin
                        if (TX_CYC_I) seen <= 1'b1;
                        if (xfer) begin
                            if (last_sym) begin
                                sym_cnt <= '0;
                                state   <= DRAIN;
                            end else begin
                                sym_cnt <= sym_cnt + LEN_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // Wait for the TX output frame to rise and fall.
                        if (TX_CYC_I) begin
                            seen <= 1'b1;
                        end else if (seen) begin
                            seen    <= 1'b0;
                            frm_cnt <= frm_nxt;
                            if (frm_nxt == num_q) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else if (gap_q == '0) begin
                                state <= XFER;
                            end else begin
                                gap_cnt <= gap_q;
                                state   <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - LEN_W'(1);
                        if (gap_cnt == LEN_W'(1)) state <= XFER;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
